// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag bit positions and sequencer states.
// The control unit imports the same opcode and flag constants.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SLL  = 4'h1,
    OP_SLT  = 4'h2,
    OP_SLTU = 4'h3,
    OP_XOR  = 4'h4,
    OP_SRL  = 4'h5,
    OP_OR   = 4'h6,
    OP_AND  = 4'h7,
    OP_SUB  = 4'h8,
    OP_SRA  = 4'hD
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: sum = a + b, or a + ~b + 1 when sub is set.
// Carry-out of the subtract is 1 when no borrow occurs.
module alu_addsub #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] sum,
  output logic            carry,
  output logic            overflow
);

  logic [XLEN-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
  // Signed overflow: both addends share a sign that the sum does not.
  assign overflow = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, one-bit-per-cycle shifts,
// valid/ready on both sides with a registered result and {N,Z,C,V} flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  localparam int SHW = $clog2(XLEN);

  state_t          state_reg, state_next;
  alu_op_t         shop_reg, shop_next;
  logic [XLEN-1:0] work_reg, work_next;
  logic [SHW-1:0]  cnt_reg, cnt_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic [3:0]      flags_reg, flags_next;

  alu_op_t         op;
  logic [XLEN-1:0] sum;
  logic            carry;
  logic            ovf;
  logic [XLEN-1:0] op_res;
  logic [3:0]      op_flags;
  logic [XLEN-1:0] shifted;

  function automatic logic [3:0] nz_flags(logic [XLEN-1:0] r);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = r[XLEN-1];
    f[FLAG_Z] = (r == '0);
    return f;
  endfunction

  assign op = alu_op_t'(alu_op);

  alu_addsub #(.XLEN(XLEN)) u_addsub (
    .a        (a),
    .b        (b),
    .sub      (op != OP_ADD),
    .sum      (sum),
    .carry    (carry),
    .overflow (ovf)
  );

  // Result of an op that completes straight from IDLE (includes zero-amount shifts).
  always_comb begin
    op_res = '0;
    case (op)
      OP_ADD, OP_SUB: op_res = sum;
      OP_SLT:         op_res = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf};
      OP_SLTU:        op_res = {{(XLEN-1){1'b0}}, ~carry};
      OP_XOR:         op_res = a ^ b;
      OP_OR:          op_res = a | b;
      OP_AND:         op_res = a & b;
      OP_SLL, OP_SRL, OP_SRA: op_res = a;
      default:        op_res = '0;
    endcase
    op_flags = nz_flags(op_res);
    if (op == OP_ADD || op == OP_SUB) begin
      op_flags[FLAG_C] = carry;
      op_flags[FLAG_V] = ovf;
    end
  end

  always_comb begin
    case (shop_reg)
      OP_SLL:  shifted = {work_reg[XLEN-2:0], 1'b0};
      OP_SRA:  shifted = {work_reg[XLEN-1], work_reg[XLEN-1:1]};
      default: shifted = {1'b0, work_reg[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    shop_next   = shop_reg;
    work_next   = work_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (is_shift(op) && (b[SHW-1:0] != '0)) begin
              work_next  = a;
              cnt_next   = b[SHW-1:0];
              shop_next  = op;
              state_next = SHIFT;
            end else begin
              result_next = op_res;
              flags_next  = op_flags;
              state_next  = DONE;
            end
          end
        end
        SHIFT: begin
          work_next = shifted;
          cnt_next  = cnt_reg - 1'b1;
          if (cnt_reg == SHW'(1)) begin
            result_next = shifted;
            flags_next  = nz_flags(shifted);
            state_next  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shop_reg   <= OP_SLL;
      work_reg   <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      flags_reg  <= 4'b0000;
    end else begin
      state_reg  <= state_next;
      shop_reg   <= shop_next;
      work_reg   <= work_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule
